memory_access_unit: RTL

//   Byte-serial memory sequencer directly downstream of the address register file.

---
 rtl/memory_access_unit.sv | 118 +++++++++++
 1 files changed

// File: rtl/memory_access_unit.sv
// Byte-serial sequencer turning one 1/2/4-byte request into a run of single-byte
// accesses on an 8-bit synchronous memory, little-endian, with start/busy/done.
module memory_access_unit #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              write,
    input  logic [1:0]        size,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] wdata,
    input  logic [7:0]        mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        dbg_state
);

    localparam int NB = DATA_W / 8;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Handshake: start is a strobe honoured only in IDLE; each accepted request
    // yields exactly one done pulse, each illegal-size request one err pulse.
    state_t            state, state_next;
    logic [CW-1:0]     cnt, n_last, cap_idx;
    logic [ADDR_W-1:0] base_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    logic              write_q, err_q;
    logic              accept, reject, last_byte;

    always_comb begin
        accept    = (state == IDLE) && start && (size != 2'b11);
        reject    = (state == IDLE) && start && (size == 2'b11);
        last_byte = (cnt == n_last);
        cap_idx   = cnt - CW'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = ACCESS;
            ACCESS:  if (last_byte) state_next = write_q ? DONE : CAPTURE;
            CAPTURE: state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Memory read data lags the address by one cycle, so the byte captured in
    // each ACCESS cycle belongs to the previous address; CAPTURE takes the last.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            n_last  <= '0;
            base_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= reject;
            case (state)
                IDLE: begin
                    if (accept) begin
                        base_q  <= address;
                        wdata_q <= wdata;
                        write_q <= write;
                        cnt     <= '0;
                        case (size)
                            2'b00:   n_last <= CW'(0);
                            2'b01:   n_last <= CW'(1);
                            default: n_last <= CW'(3);
                        endcase
                        if (!write) rdata_q <= '0;
                    end
                end
                ACCESS: begin
                    cnt <= cnt + CW'(1);
                    if (!write_q && (cnt != '0)) rdata_q[8*cap_idx +: 8] <= mem_rdata;
                end
                CAPTURE: rdata_q[8*n_last +: 8] <= mem_rdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_cs    = (state == ACCESS);
        mem_we    = mem_cs && write_q;
        mem_addr  = mem_cs ? (base_q + ADDR_W'(cnt)) : '0;
        mem_wdata = mem_we ? wdata_q[8*cnt +: 8] : 8'h00;
        busy      = (state == ACCESS) || (state == CAPTURE);
        done      = (state == DONE);
        err       = err_q;
        rdata     = rdata_q;
        dbg_state = state;
    end

endmodule
